// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter.
// ALU op encodings, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant with a last-grant register.
// Grant is combinational; last_grant only moves when enabled.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): gnt_id = ~last_q;
      (valid == 2'b10): gnt_id = 1'b1;
      default:          gnt_id = 1'b0;
    endcase
    grant  = 2'b00;
    last_d = last_q;
    if (en && (|valid)) begin
      grant  = gnt_id ? 2'b10 : 2'b01;
      last_d = gnt_id;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// IDLE grants and latches operands, EXEC settles, RESP returns result.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  input  logic             alu_overflow
);
  import alu_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  alu_op_e          op_q, op_d;
  logic             gid_q, gid_d;
  logic             rid_q, rid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;

  logic [1:0] grant;
  logic       gnt_id;
  logic       arb_en;

  assign arb_en = (state_q == S_IDLE);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .en     (arb_en),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = rid_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flg_q;
  assign alu_srca    = srca_q;
  assign alu_srcb    = srcb_q;
  assign alu_control = op_q;

  always_comb begin
    state_d = state_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    op_d    = op_q;
    gid_d   = gid_q;
    rid_d   = rid_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          srca_d  = gnt_id ? req1_a : req0_a;
          srcb_d  = gnt_id ? req1_b : req0_b;
          op_d    = alu_op_e'(gnt_id ? req1_op : req0_op);
          gid_d   = gnt_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        flg_d   = pack_flags(alu_negative, alu_zero,
                             alu_carry, alu_overflow);
        rid_d   = gid_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      srca_q  <= '0;
      srcb_q  <= '0;
      op_q    <= ALU_ADD;
      gid_q   <= 1'b0;
      rid_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      op_q    <= op_d;
      gid_q   <= gid_d;
      rid_q   <= rid_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (SrcA/SrcB/ALUControl in; ALUResult, Zero/Negative/Overflow/Carry out) between two requesters, e.g. the main datapath and an address/branch helper.
- Uses valid/ready round-robin arbitration. Operands and op are registered onto the ALU. Result and flags are captured and returned on one response channel, tagged with the requester id.
- Sits beside the ALU instance; the ALU stays purely combinational and external to this block.

Parameters:
- WIDTH, 32, operand/result width (ALU datapath width).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 SrcA.
- req0_b  in  WIDTH  requester 0 SrcB.
- req0_op  in  2  requester 0 ALUControl.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  WIDTH  captured ALUResult.
- rsp_flags  out  4  captured {Negative, Zero, Carry, Overflow}.
- alu_srca  out  WIDTH  to ALU SrcA.
- alu_srcb  out  WIDTH  to ALU SrcB.
- alu_control  out  2  to ALU ALUControl.
- alu_result  in  WIDTH  from ALU ALUResult.
- alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  from ALU flags.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; alu_srca/alu_srcb=0; alu_control=2'b00; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; last_grant=1 (so requester 0 wins the first tie).
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant: one valid -> that requester. Both valid -> the requester != last_grant.
  - On grant: reqX_ready=1 for that cycle; operands/op latched into alu_srca/alu_srcb/alu_control; grant id latched; last_grant updated; go EXEC.
  - No valid: stay IDLE with registers unchanged.
- EXEC: exactly one cycle for the ALU to settle. At the end of the cycle, capture alu_result and flags into rsp_result/rsp_flags and rsp_id <= grant id; go RESP.
- RESP: rsp_valid=1.
  - rsp_ready=1 -> handshake, go IDLE.
  - Otherwise hold; rsp_* stable until accepted.
- Ready rules:
  - reqX_ready is high only in IDLE and only for the granted requester; it is combinational from req valids and state.
  - Requesters must not make valid depend on ready.
  - A requester holds valid/operands stable until ready.
- Latency: request accept -> rsp_valid two cycles later. Throughput is one op per 3 cycles with rsp_ready tied high.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- No new grant while in EXEC or RESP; a valid arriving then waits.
- ALU operand registers hold their last values after EXEC (no toggling when idle).
- rsp_flags bit order [3]=N, [2]=Z, [1]=C, [0]=V; values pass through from the ALU unmodified.
- Reset mid-operation (EXEC/RESP): the operation is discarded, rsp_valid drops immediately, and no response is issued after reset.

Decomposition:
- Shared package alu_pkg:
  - ALUControl encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - FSM state encoding (IDLE/EXEC/RESP).
  - Flag bit indices FLAG_N/Z/C/V.
- One natural sub-module: rr_arbiter2 (combinational grant from two valids plus the last_grant register, with an update-enable).

Test Plan:
- Single req0 op=ADD, a=32'h4, b=32'h5 -> req0_ready one cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_result=32'h9, Z=0, N=0.
- req1 op=SUB, a=b=32'h5 -> rsp_id=1, rsp_result=0, Z=1, N=0, C=1 (ALU no-borrow convention).
- Both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1.
- req0 op=AND, a=32'hF0F0F0F0, b=32'hFF00FF00; rsp_ready held low 5 cycles -> rsp_valid stays high, rsp_result=32'hF000F000 stable; req1_valid asserted meanwhile gets no ready until after the response handshake.
- rst_n pulsed low during EXEC -> all outputs at reset values immediately; no rsp_valid afterwards; next req (op=OR, a=32'h1, b=32'h2) returns 32'h3.
